// File: rtl/videoram_pkg.sv
// Shared constants and FSM state type for the videoram scanout block.
package videoram_pkg;
  localparam int unsigned VRAM_ADDR_W  = 12;
  localparam int unsigned VRAM_DATA_W  = 32;
  localparam int unsigned PIX_W        = 8;
  localparam int unsigned PIX_PER_WORD = 4;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} vram_state_e;
endpackage

// File: rtl/videoram_word_fifo.sv
// Synchronous word FIFO between the RAM return path and the pixel serializer.
module videoram_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/videoram_scanout.sv
// Raster-order reader of the 32-bit video RAM, emitting an 8-bit pixel stream
// (byte 0 first) with valid/ready, start-of-frame and end-of-line flags.
module videoram_scanout
  import videoram_pkg::*;
#(
  parameter int unsigned ADDR_W         = VRAM_ADDR_W,
  parameter int unsigned WORDS_PER_LINE = 32,
  parameter int unsigned LINES          = 128,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic                     enable,
  output logic [ADDR_W-1:0]        videoram_address,
  output logic                     videoram_chipselect,
  output logic                     videoram_clken,
  output logic                     videoram_write,
  output logic [VRAM_DATA_W-1:0]   videoram_writedata,
  output logic [VRAM_DATA_W/8-1:0] videoram_byteenable,
  input  logic [VRAM_DATA_W-1:0]   videoram_readdata,
  output logic [PIX_W-1:0]         pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     pix_sof,
  output logic                     pix_eol,
  output logic                     frame_done,
  output logic                     busy
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IDX_W = $clog2(PIX_PER_WORD);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_LINE * LINES - 1);
  localparam logic [ADDR_W-1:0] WPL       = ADDR_W'(WORDS_PER_LINE);

  vram_state_e             state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d, pop_cnt_q, pop_cnt_d, widx_q, widx_d;
  logic [RD_LAT-1:0]       pipe_q, pipe_d;
  logic [VRAM_DATA_W-1:0]  word_q, word_d, fifo_rdata;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    valid_q, valid_d, last_acc_q, last_acc_d;
  logic [CNT_W-1:0]        fifo_count, inflight, used;
  logic                    fifo_full, fifo_empty;
  logic                    issue, push, pop, fire, last_byte, start, done;

  assign videoram_clken      = 1'b1;
  assign videoram_write      = 1'b0;
  assign videoram_writedata  = '0;
  assign videoram_byteenable = '1;
  assign videoram_address    = addr_q;
  assign videoram_chipselect = issue;
  assign busy                = (state_q != IDLE);
  assign frame_done          = done;

  assign fire      = valid_q && pix_ready;
  assign last_byte = (idx_q == '1);
  assign push      = pipe_q[RD_LAT-1];
  assign pop       = !fifo_empty && (!valid_q || (fire && last_byte));
  assign used      = fifo_count + inflight;

  assign pix_valid = valid_q;
  assign pix_data  = word_q[PIX_W*idx_q +: PIX_W];
  assign pix_sof   = valid_q && (idx_q == '0) && (widx_q == '0);
  assign pix_eol   = valid_q && last_byte && ((widx_q % WPL) == WPL - ADDR_W'(1));

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(pipe_q[i]);
  end

  videoram_word_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(VRAM_DATA_W)
  ) u_fifo (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .push_i  (push),
    .wdata_i (videoram_readdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Completion with enable still high goes straight back to FETCH so the
  // next frame starts without an idle cycle.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done    = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = FETCH;
          start   = 1'b1;
        end
      end
      FETCH: begin
        issue = (used < CNT_W'(FIFO_DEPTH)) && !fifo_full;
        if (issue && addr_q == LAST_ADDR) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && inflight == '0 && last_acc_q) begin
          done    = 1'b1;
          start   = enable;
          state_d = enable ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    pop_cnt_d  = pop_cnt_q;
    widx_d     = widx_q;
    word_d     = word_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    last_acc_d = last_acc_q;
    pipe_d     = (pipe_q << 1) | RD_LAT'(issue);
    if (start) begin
      addr_d    = '0;
      pop_cnt_d = '0;
    end else begin
      if (issue && addr_q != LAST_ADDR) addr_d = addr_q + ADDR_W'(1);
      if (pop) pop_cnt_d = pop_cnt_q + ADDR_W'(1);
    end
    if (done) last_acc_d = 1'b0;
    else if (fire && last_byte && widx_q == LAST_ADDR) last_acc_d = 1'b1;
    if (pop) begin
      word_d  = fifo_rdata;
      widx_d  = pop_cnt_q;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (fire) begin
      idx_d = idx_q + IDX_W'(1);
      if (last_byte) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      addr_q     <= '0;
      pop_cnt_q  <= '0;
      widx_q     <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      last_acc_q <= 1'b0;
      pipe_q     <= '0;
    end else begin
      addr_q     <= addr_d;
      pop_cnt_q  <= pop_cnt_d;
      widx_q     <= widx_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      last_acc_q <= last_acc_d;
      pipe_q     <= pipe_d;
    end
  end
endmodule
